// File: rtl/live_monitor_scheduler_pkg.sv
// Shared definitions for the heartbeat supervisor: channel state encoding and default timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package live_pkg;

    // Channel state encoding carried on the status port; 2'b11 is never produced and reads as UNKNOWN.
    typedef logic [1:0] live_st_t;

    localparam live_st_t ST_UNKNOWN = 2'b00;
    localparam live_st_t ST_ALIVE   = 2'b01;
    localparam live_st_t ST_DEAD    = 2'b10;

    // Front-end boards toggle their live line every 2^29 clk; silence of twice that means DEAD.
    localparam int LIVE_HALF_PERIOD = 2**29;
    localparam int LIVE_TIMEOUT     = 2 * LIVE_HALF_PERIOD;

endpackage

// File: rtl/live_monitor_scheduler_if.sv
// Status event bus: one channel-state event per valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds evt_ch/evt_state while evt_valid & !evt_ready.
//  master: drives evt_valid, evt_ch, evt_state; samples evt_ready.
//  slave : samples evt_valid, evt_ch, evt_state; drives evt_ready.
interface live_monitor_scheduler_if
    import live_pkg::*;
#(
    parameter int CH_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    live_st_t        evt_state;

    modport master (output evt_valid, output evt_ch, output evt_state, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_state, output evt_ready);
endinterface

// File: rtl/live_monitor_scheduler_channel.sv
// One heartbeat line: synchroniser, edge detect, silence counter and UNKNOWN/ALIVE/DEAD FSM.
// Latency: live_in change to state update = 3 clk (2 sync FFs + state register).
// Backpressure: none; trans is a one-cycle strobe, the parent latches it.
//  clk, rst_n : clock, async active-low reset
//  live_in    : raw heartbeat line (asynchronous)
//  enable     : 0 forces UNKNOWN and holds the counter at 0
//  state      : registered channel state (ST_* encoding)
//  trans      : high in the cycle whose clock edge moves state to ALIVE or DEAD
module live_channel_monitor
    import live_pkg::*;
#(
    parameter int CNT_W   = 31,
    parameter int TIMEOUT = LIVE_TIMEOUT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     live_in,
    input  logic     enable,
    output live_st_t state,
    output logic     trans
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    logic             sync1, sync2, prev;
    logic             edge_det;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    live_st_t         st_nxt;

    // Either polarity of the synchronised line counts as a heartbeat.
    assign edge_det = sync2 ^ prev;

    always_comb begin
        cnt_nxt = cnt;
        st_nxt  = state;
        if (!enable) begin
            cnt_nxt = '0;
            st_nxt  = ST_UNKNOWN;
        end else begin
            if (edge_det)
                cnt_nxt = '0;
            else if (cnt < TO)
                cnt_nxt = cnt + CNT_W'(1);
            // Timeout is judged on the value the counter is about to take, so DEAD lands on
            // the same edge that brings the counter to TIMEOUT; an edge in that cycle wins.
            if (edge_det)
                st_nxt = ST_ALIVE;
            else if (cnt_nxt >= TO)
                st_nxt = ST_DEAD;
        end
    end

    // Disabling is not an event, so no strobe while enable is low.
    assign trans = enable && (st_nxt != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
            state <= ST_UNKNOWN;
        end else begin
            sync1 <= live_in;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_nxt;
            state <= st_nxt;
        end
    end

endmodule

// File: rtl/live_monitor_scheduler.sv
// Supervises NCH heartbeat lines and serialises state-change events round-robin onto one status port.
// Latency: live_in change to mask = 3 clk; to evt_valid = 4 clk when the port is idle.
// Backpressure: evt payload held while evt_valid & !evt_ready; further changes coalesce in pending bits.
//  clk, rst_n            : clock, async active-low reset
//  live_in, ch_enable    : heartbeat lines (async) and per-channel monitor enables
//  alive_mask, dead_mask : per-channel ALIVE / DEAD flags (enabled channels only)
//  all_alive             : every enabled channel ALIVE, and at least one enabled
//  evt                   : status event port (evt_valid/evt_ready/evt_ch/evt_state)
module live_monitor_scheduler
    import live_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 31,
    parameter int TIMEOUT = LIVE_TIMEOUT,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           live_in,
    input  logic [NCH-1:0]           ch_enable,
    output logic [NCH-1:0]           alive_mask,
    output logic [NCH-1:0]           dead_mask,
    output logic                     all_alive,
    live_monitor_scheduler_if.master evt
);

    live_st_t        st [NCH];
    logic [NCH-1:0]  trans;
    logic [NCH-1:0]  pending, pend_nxt;
    logic [CH_W-1:0] rr, rr_nxt;
    logic [CH_W-1:0] win, cand;
    logic            found, load;
    int              s;

    logic            evt_valid_q;
    logic [CH_W-1:0] evt_ch_q;
    live_st_t        evt_state_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        live_channel_monitor #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_mon (
            .clk     (clk),
            .rst_n   (rst_n),
            .live_in (live_in[g]),
            .enable  (ch_enable[g]),
            .state   (st[g]),
            .trans   (trans[g])
        );
    end

    always_comb begin
        alive_mask = '0;
        dead_mask  = '0;
        for (int i = 0; i < NCH; i++) begin
            alive_mask[i] = ch_enable[i] && (st[i] == ST_ALIVE);
            dead_mask[i]  = ch_enable[i] && (st[i] == ST_DEAD);
        end
    end

    // Disabled channels are ignored; with none enabled the AND would be vacuously true, so gate it.
    assign all_alive = (|ch_enable) & (&(alive_mask | ~ch_enable));

    // A new slot opens when the port is empty or its current event is being taken.
    assign load = !evt_valid_q || evt.evt_ready;

    // First pending channel at or after the rr pointer, wrapping at NCH-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        s     = 0;
        for (int i = 0; i < NCH; i++) begin
            s = int'(rr) + i;
            if (s >= NCH)
                s = s - NCH;
            cand = CH_W'(s);
            if (!found && pending[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign rr_nxt = (int'(win) == NCH - 1) ? '0 : win + CH_W'(1);

    // Clear first, then OR in fresh strobes so a transition on the channel being loaded survives.
    always_comb begin
        pend_nxt = pending;
        if (load && found)
            pend_nxt[win] = 1'b0;
        pend_nxt = (pend_nxt | trans) & ch_enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            rr          <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_state_q <= ST_UNKNOWN;
        end else begin
            pending <= pend_nxt;
            if (load) begin
                evt_valid_q <= found;
                if (found) begin
                    evt_ch_q    <= win;
                    evt_state_q <= st[win];
                    rr          <= rr_nxt;
                end
            end
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_ch    = evt_ch_q;
    assign evt.evt_state = evt_state_q;

endmodule

// File: tb/tb_live_monitor_scheduler.sv
// Directed bench for live_monitor_scheduler with NCH=4, TIMEOUT=64.
// Latency: n/a.
// Backpressure: evt_ready driven directly by the scenarios.
module tb_live_monitor_scheduler;

    localparam logic [1:0] S_UNK   = 2'b00;
    localparam logic [1:0] S_ALIVE = 2'b01;
    localparam logic [1:0] S_DEAD  = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] live_in = 4'h0;
    logic [3:0] ch_enable = 4'hF;
    logic [3:0] alive_mask, dead_mask;
    logic       all_alive;

    logic [3:0] keep_mask = 4'h0;
    int         ph = 0;
    int         checks = 0;
    int         errors = 0;
    int         q_ch[$];
    int         q_st[$];

    live_monitor_scheduler_if #(.CH_W(2)) evt_if ();

    live_monitor_scheduler #(
        .NCH     (4),
        .CNT_W   (31),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .live_in    (live_in),
        .ch_enable  (ch_enable),
        .alive_mask (alive_mask),
        .dead_mask  (dead_mask),
        .all_alive  (all_alive),
        .evt        (evt_if)
    );

    always #5 clk = ~clk;

    // Accepted events, sampled on the falling edge ahead of the accepting rising edge.
    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            q_ch.push_back(int'(evt_if.evt_ch));
            q_st.push_back(int'(evt_if.evt_state));
        end
    end

    // Advance n clocks; channels in keep_mask toggle every 20 clk to stay ALIVE.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ph++;
            if (ph >= 20) begin
                ph = 0;
                live_in = live_in ^ keep_mask;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        live_in = 4'h0;
        ch_enable = 4'hF;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_if.evt_valid); end
        checks++; if (alive_mask !== 4'h0) begin errors++; $display("FAIL reset_alive: got %h expected 0", alive_mask); end
        checks++; if (dead_mask !== 4'h0) begin errors++; $display("FAIL reset_dead: got %h expected 0", dead_mask); end
        checks++; if (all_alive !== 1'b0) begin errors++; $display("FAIL reset_all_alive: got %b expected 0", all_alive); end
        checks++; if (evt_if.evt_ch !== 2'd0 || evt_if.evt_state !== S_UNK) begin errors++; $display("FAIL reset_payload: got ch %0d st %0d expected 0 0", evt_if.evt_ch, evt_if.evt_state); end
        run(63);
        checks++; if (dead_mask !== 4'h0) begin errors++; $display("FAIL dead_before_timeout: got %h expected 0", dead_mask); end
        run(1);
        checks++; if (dead_mask !== 4'hF) begin errors++; $display("FAIL dead_at_timeout: got %h expected f", dead_mask); end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL evt_not_yet: got %b expected 0", evt_if.evt_valid); end
        run(8);
        checks++; if (q_ch.size() != 4) begin errors++; $display("FAIL dead_evt_count: got %0d expected 4", q_ch.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (q_ch[i] != i || q_st[i] != int'(S_DEAD)) begin errors++; $display("FAIL dead_evt_%0d: got ch %0d st %0d expected ch %0d st 2", i, q_ch[i], q_st[i], i); end
            end
        end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL dead_evt_drained: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_alive;
        q_ch.delete(); q_st.delete();
        live_in[2] = ~live_in[2];
        run(2);
        checks++; if (alive_mask !== 4'h0) begin errors++; $display("FAIL alive_early: got %h expected 0", alive_mask); end
        run(1);
        checks++; if (alive_mask !== 4'h4 || dead_mask !== 4'hB) begin errors++; $display("FAIL alive_at_3: got a %h d %h expected a 4 d b", alive_mask, dead_mask); end
        run(1);
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL alive_evt: got v %b ch %0d st %0d expected v 1 ch 2 st 1", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        run(16);
        repeat (9) begin
            live_in[2] = ~live_in[2];
            run(20);
        end
        checks++; if (q_ch.size() != 1) begin errors++; $display("FAIL alive_single_evt: got %0d events expected 1", q_ch.size()); end
        checks++; if (alive_mask !== 4'h4) begin errors++; $display("FAIL alive_held: got %h expected 4", alive_mask); end
    endtask

    task automatic test_dead_recovery;
        live_in[2] = ~live_in[2];
        run(66);
        checks++; if (dead_mask !== 4'hB) begin errors++; $display("FAIL dead2_early: got %h expected b", dead_mask); end
        run(1);
        checks++; if (dead_mask !== 4'hF || alive_mask !== 4'h0) begin errors++; $display("FAIL dead2_at_64: got d %h a %h expected d f a 0", dead_mask, alive_mask); end
        run(1);
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2 || evt_if.evt_state !== S_DEAD) begin errors++; $display("FAIL dead2_evt: got v %b ch %0d st %0d expected v 1 ch 2 st 2", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        live_in[2] = ~live_in[2];
        run(3);
        checks++; if (alive_mask !== 4'h4) begin errors++; $display("FAIL recover_mask: got %h expected 4", alive_mask); end
        run(1);
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL recover_evt: got v %b ch %0d st %0d expected v 1 ch 2 st 1", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        keep_mask = 4'h4;
        ph = 0;
        run(2);
    endtask

    task automatic test_stall;
        evt_if.evt_ready = 1'b0;
        live_in[1] = ~live_in[1];
        run(1);
        live_in[3] = ~live_in[3];
        keep_mask = keep_mask | 4'h2;
        run(3);
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL stall_first: got v %b ch %0d st %0d expected v 1 ch 1 st 1", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        checks++; if (alive_mask !== 4'hE) begin errors++; $display("FAIL stall_alive: got %h expected e", alive_mask); end
        run(70);
        checks++; if (dead_mask !== 4'h9) begin errors++; $display("FAIL flap_dead: got %h expected 9", dead_mask); end
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL stall_hold1: got v %b ch %0d st %0d expected v 1 ch 1 st 1", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        live_in[3] = ~live_in[3];
        run(4);
        checks++; if (alive_mask !== 4'hE) begin errors++; $display("FAIL flap_alive: got %h expected e", alive_mask); end
        checks++; if (evt_if.evt_ch !== 2'd1 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL stall_hold2: got ch %0d st %0d expected ch 1 st 1", evt_if.evt_ch, evt_if.evt_state); end
        keep_mask = keep_mask | 4'h8;
        q_ch.delete(); q_st.delete();
        evt_if.evt_ready = 1'b1;
        run(5);
        checks++; if (q_ch.size() != 2) begin errors++; $display("FAIL release_count: got %0d expected 2", q_ch.size()); end
        else begin
            checks++; if (q_ch[0] != 1 || q_st[0] != int'(S_ALIVE)) begin errors++; $display("FAIL release_0: got ch %0d st %0d expected ch 1 st 1", q_ch[0], q_st[0]); end
            checks++; if (q_ch[1] != 3 || q_st[1] != int'(S_ALIVE)) begin errors++; $display("FAIL release_1: got ch %0d st %0d expected ch 3 st 1", q_ch[1], q_st[1]); end
        end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL release_drained: got %b expected 0", evt_if.evt_valid); end
    endtask

    task automatic test_edge_at_timeout;
        q_ch.delete(); q_st.delete();
        live_in[0] = ~live_in[0];
        run(3);
        checks++; if (alive_mask !== 4'hF) begin errors++; $display("FAIL ch0_alive: got %h expected f", alive_mask); end
        run(61);
        live_in[0] = ~live_in[0];
        run(3);
        checks++; if (dead_mask !== 4'h0 || alive_mask !== 4'hF) begin errors++; $display("FAIL edge_wins: got d %h a %h expected d 0 a f", dead_mask, alive_mask); end
        keep_mask = keep_mask | 4'h1;
        run(60);
        checks++; if (dead_mask !== 4'h0 || all_alive !== 1'b1) begin errors++; $display("FAIL all_alive_on: got d %h all %b expected d 0 all 1", dead_mask, all_alive); end
        checks++; if (q_ch.size() != 1) begin errors++; $display("FAIL edge_evt_count: got %0d expected 1", q_ch.size()); end
        else begin
            checks++; if (q_ch[0] != 0 || q_st[0] != int'(S_ALIVE)) begin errors++; $display("FAIL edge_evt: got ch %0d st %0d expected ch 0 st 1", q_ch[0], q_st[0]); end
        end
    endtask

    task automatic test_disable;
        q_ch.delete(); q_st.delete();
        ch_enable = 4'hE;
        run(1);
        checks++; if (alive_mask !== 4'hE || all_alive !== 1'b1) begin errors++; $display("FAIL dis_mask: got a %h all %b expected a e all 1", alive_mask, all_alive); end
        run(100);
        checks++; if (q_ch.size() != 0 || dead_mask !== 4'h0) begin errors++; $display("FAIL dis_silent: got %0d events d %h expected 0 events d 0", q_ch.size(), dead_mask); end
        keep_mask = 4'h7;
        run(100);
        checks++; if (dead_mask !== 4'h8 || all_alive !== 1'b0) begin errors++; $display("FAIL ch3_dead: got d %h all %b expected d 8 all 0", dead_mask, all_alive); end
        checks++; if (q_ch.size() != 1) begin errors++; $display("FAIL ch3_evt_count: got %0d expected 1", q_ch.size()); end
        else begin
            checks++; if (q_ch[0] != 3 || q_st[0] != int'(S_DEAD)) begin errors++; $display("FAIL ch3_evt: got ch %0d st %0d expected ch 3 st 2", q_ch[0], q_st[0]); end
        end
        ch_enable = 4'h6;
        run(1);
        checks++; if (all_alive !== 1'b1) begin errors++; $display("FAIL all_alive_subset: got %b expected 1", all_alive); end
        ch_enable = 4'h0;
        run(1);
        checks++; if (all_alive !== 1'b0 || alive_mask !== 4'h0) begin errors++; $display("FAIL none_enabled: got all %b a %h expected all 0 a 0", all_alive, alive_mask); end
        run(3);
        checks++; if (q_ch.size() != 1) begin errors++; $display("FAIL disable_no_evt: got %0d events expected 1", q_ch.size()); end
    endtask

    task automatic test_reset_midop;
        rst_n = 1'b0;
        live_in = 4'h0;
        keep_mask = 4'h0;
        ch_enable = 4'hF;
        evt_if.evt_ready = 1'b0;
        run(3);
        rst_n = 1'b1;
        live_in[0] = 1'b1;
        run(1);
        live_in[1] = 1'b1;
        live_in[3] = 1'b1;
        run(3);
        checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0 || evt_if.evt_state !== S_ALIVE) begin errors++; $display("FAIL pre_reset_evt: got v %b ch %0d st %0d expected v 1 ch 0 st 1", evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_state); end
        checks++; if (alive_mask !== 4'hB) begin errors++; $display("FAIL pre_reset_alive: got %h expected b", alive_mask); end
        rst_n = 1'b0;
        #1;
        checks++; if (evt_if.evt_valid !== 1'b0 || alive_mask !== 4'h0) begin errors++; $display("FAIL async_reset: got v %b a %h expected v 0 a 0", evt_if.evt_valid, alive_mask); end
        checks++; if (evt_if.evt_ch !== 2'd0 || evt_if.evt_state !== S_UNK) begin errors++; $display("FAIL async_reset_payload: got ch %0d st %0d expected 0 0", evt_if.evt_ch, evt_if.evt_state); end
        live_in = 4'h0;
        q_ch.delete(); q_st.delete();
        run(2);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        run(30);
        checks++; if (q_ch.size() != 0 || evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL no_replay: got %0d events v %b expected 0 events v 0", q_ch.size(), evt_if.evt_valid); end
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_alive();
        test_dead_recovery();
        test_stall();
        test_edge_at_timeout();
        test_disable();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
